// File: rtl/ocm_read_responder.sv
// OCM read responder: fetches one DATA_W beat per rising edge of init_master_txn and
// frames it for dfsm. Define OCM_RESP_STATS_EN to add the beat_count/drop_count ports.
module ocm_read_responder #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MAX_INDEX   = 1023,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_master_txn,
  input  logic [31:0]       read_addr_index,
  input  logic              dfsm_read_ready,
  output logic              read_active,
  output logic              bus_data_valid,
  output logic [DATA_W-1:0] ocm_data_out,
  output logic              read_done,
  output logic              read_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef OCM_RESP_STATS_EN
  ,
  output logic [15:0]       beat_count,
  output logic [15:0]       drop_count
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                txn_q;
  logic [31:0]         idx_q, idx_d;
  logic [3:0]          lat_q, lat_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                start;
  logic                busy;
  logic                out_of_range;

  assign start        = init_master_txn & ~txn_q;
  assign busy         = (state_q == StIssue) || (state_q == StWait) || (state_q == StResp);
  // Range check uses the full 32-bit index, not just the address bits.
  assign out_of_range = idx_q > MAX_INDEX;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    lat_d          = lat_q;
    err_d          = err_q;
    data_d         = data_q;
    done_d         = done_q;
    mem_en         = 1'b0;
    mem_addr       = '0;
    bus_data_valid = 1'b0;
    read_err       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          idx_d   = read_addr_index;
          done_d  = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (out_of_range) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = StResp;
        end else begin
          err_d    = 1'b0;
          mem_en   = 1'b1;
          mem_addr = idx_q[ADDR_W-1:0];
          lat_d    = 4'(MEM_LATENCY - 1);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (lat_q == 4'd0) begin
          data_d  = mem_rdata;
          state_d = StResp;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      StResp: begin
        if (dfsm_read_ready) begin
          bus_data_valid = 1'b1;
          read_err       = err_q;
          done_d         = 1'b1;
          state_d        = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      txn_q   <= 1'b0;
      idx_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= init_master_txn;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign read_active  = busy;
  assign ocm_data_out = data_q;
  // The strobe cycle already reports done; the register keeps it up afterwards.
  assign read_done    = done_q | bus_data_valid;

`ifdef OCM_RESP_STATS_EN
  logic [15:0] beat_q, drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
      drop_q <= '0;
    end else begin
      if (bus_data_valid) begin
        beat_q <= beat_q + 16'd1;
      end
      if (start && busy && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign beat_count = beat_q;
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_ocm_read_responder.sv
// Scoreboard bench for ocm_read_responder: expected beats are queued at each start and
// checked against every bus_data_valid strobe.
module tb_ocm_read_responder;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              reset_n;
  logic              init_master_txn;
  logic [31:0]       read_addr_index;
  logic              dfsm_read_ready;
  logic              read_active;
  logic              bus_data_valid;
  logic [DATA_W-1:0] ocm_data_out;
  logic              read_done;
  logic              read_err;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
`ifdef OCM_RESP_STATS_EN
  logic [15:0]       beat_count;
  logic [15:0]       drop_count;
`endif

  int tests;
  int fails;
  int strobe_cnt;
  bit mem_en_seen;
  logic [DATA_W:0] exp_q[$];

  logic [DATA_W-1:0] mem [0:1023];
  logic [DATA_W-1:0] rd_s1, rd_s2;

  ocm_read_responder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .init_master_txn (init_master_txn),
    .read_addr_index (read_addr_index),
    .dfsm_read_ready (dfsm_read_ready),
    .read_active     (read_active),
    .bus_data_valid  (bus_data_valid),
    .ocm_data_out    (ocm_data_out),
    .read_done       (read_done),
    .read_err        (read_err),
    .mem_en          (mem_en),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata)
`ifdef OCM_RESP_STATS_EN
    ,
    .beat_count      (beat_count),
    .drop_count      (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle registered memory model
  always @(posedge clk) begin
    if (mem_en) rd_s1 <= mem[mem_addr];
    rd_s2 <= rd_s1;
  end
  assign mem_rdata = rd_s2;

  // Strobe monitor: pops the scoreboard on every beat
  always begin
    @(negedge clk);
    #3;
    if (mem_en) mem_en_seen = 1'b1;
    if (bus_data_valid) begin
      strobe_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got data=%h err=%b, required no strobe",
                 ocm_data_out, read_err);
      end else begin
        logic [DATA_W:0] e;
        e = exp_q.pop_front();
        if ({read_err, ocm_data_out} !== e) begin
          fails++;
          $display("FAIL beat: got err=%b data=%h, required err=%b data=%h",
                   read_err, ocm_data_out, e[DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issues one request from a tick point and waits for its strobe.
  task automatic do_read(input logic [31:0] idx, input logic [DATA_W-1:0] d, input logic e,
                         input int exp_lat);
    int  k;
    bit  done_low;
    exp_q.push_back({e, d});
    init_master_txn = 1'b1;
    read_addr_index = idx;
    done_low        = 1'b1;
    tick();
    init_master_txn = 1'b0;
    k = 1;
    while (!bus_data_valid && k < 30) begin
      if (read_done !== 1'b0) done_low = 1'b0;
      tick();
      k++;
    end
    tests++;
    if (k !== exp_lat) begin
      fails++;
      $display("FAIL latency idx=%0d: got %0d cycles, required %0d", idx, k, exp_lat);
    end
    tests++;
    if (!done_low || read_done !== 1'b1) begin
      fails++;
      $display("FAIL read_done_frame idx=%0d: low_before=%b at_strobe=%b, required 1/1",
               idx, done_low, read_done);
    end
    tick();
  endtask

  task automatic test_reset();
    int n0;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({read_active, bus_data_valid, ocm_data_out, read_done, read_err, mem_en, mem_addr}
        !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    tick();
    reset_n = 1'b1;
    tick();
    // Abort a read mid-WAIT
    n0 = strobe_cnt;
    init_master_txn = 1'b1;
    read_addr_index = 32'd3;
    tick();
    init_master_txn = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    tests++;
    if ({read_active, bus_data_valid, ocm_data_out, read_done, read_err, mem_en, mem_addr}
        !== '0) begin
      fails++;
      $display("FAIL reset_mid_wait: got read_active=%b data=%h, required all 0",
               read_active, ocm_data_out);
    end
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    tests++;
    if (strobe_cnt !== n0 || read_active !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: got strobes=%0d active=%b, required %0d/0",
               strobe_cnt - n0, read_active, 0);
    end
  endtask

  task automatic test_single();
    init_master_txn = 1'b1;
    read_addr_index = 32'd3;
    exp_q.push_back({1'b0, 128'h61});
    tick();
    init_master_txn = 1'b0;
    tests++;
    if (read_active !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 10'd3) begin
      fails++;
      $display("FAIL single_issue: got active=%b mem_en=%b addr=%0d, required 1/1/3",
               read_active, mem_en, mem_addr);
    end
    tick();
    tick();
    tests++;
    if (bus_data_valid !== 1'b0 || read_done !== 1'b0) begin
      fails++;
      $display("FAIL single_early: got valid=%b done=%b at N+3, required 0/0",
               bus_data_valid, read_done);
    end
    tick();
    tests++;
    if (bus_data_valid !== 1'b1 || read_done !== 1'b1 || ocm_data_out !== 128'h61) begin
      fails++;
      $display("FAIL single_strobe: got valid=%b done=%b data=%h, required 1/1/61",
               bus_data_valid, read_done, ocm_data_out);
    end
    tick();
    tests++;
    if (read_active !== 1'b0 || read_done !== 1'b1 || bus_data_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_after: got active=%b done=%b valid=%b, required 0/1/0",
               read_active, read_done, bus_data_valid);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = strobe_cnt;
    do_read(32'd0, 128'h61, 1'b0, 4);
    do_read(32'd1, 128'h62, 1'b0, 4);
    do_read(32'd2, 128'h63, 1'b0, 4);
    tests++;
    if (strobe_cnt - n0 !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d strobes, required 3", strobe_cnt - n0);
    end
  endtask

  task automatic test_backpressure();
    bit held;
    dfsm_read_ready = 1'b0;
    init_master_txn = 1'b1;
    read_addr_index = 32'd5;
    exp_q.push_back({1'b0, mem[5]});
    tick();
    init_master_txn = 1'b0;
    repeat (3) tick();
    held = 1'b1;
    repeat (5) begin
      if (bus_data_valid !== 1'b0 || read_active !== 1'b1 || ocm_data_out !== mem[5])
        held = 1'b0;
      tick();
    end
    tests++;
    if (!held) begin
      fails++;
      $display("FAIL backpressure_hold: got valid/active/data not held, required 0/1/%h",
               mem[5]);
    end
    dfsm_read_ready = 1'b1;
    #1;
    tests++;
    if (bus_data_valid !== 1'b1 || read_done !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: got valid=%b done=%b, required 1/1",
               bus_data_valid, read_done);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    mem_en_seen = 1'b0;
    do_read(32'd1024, '0, 1'b1, 2);
    tests++;
    if (mem_en_seen !== 1'b0) begin
      fails++;
      $display("FAIL oor_mem_en: got mem_en=1, required never");
    end
    do_read(32'h8000_0003, '0, 1'b1, 2);
    mem_en_seen = 1'b0;
    do_read(32'd1023, mem[1023], 1'b0, 4);
    tests++;
    if (mem_en_seen !== 1'b1) begin
      fails++;
      $display("FAIL max_index_mem_en: got mem_en never, required 1");
    end
  endtask

  task automatic test_stats();
    int n0;
    int k;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n0 = strobe_cnt;
    init_master_txn = 1'b1;
    read_addr_index = 32'd2;
    exp_q.push_back({1'b0, 128'h63});
    tick();
    init_master_txn = 1'b0;
    tick();
    init_master_txn = 1'b1;
    tick();
    init_master_txn = 1'b0;
    k = 3;
    while (!bus_data_valid && k < 30) begin
      tick();
      k++;
    end
    tests++;
    if (k !== 4) begin
      fails++;
      $display("FAIL drop_latency: got %0d cycles, required 4", k);
    end
    tick();
    do_read(32'd0, 128'h61, 1'b0, 4);
    do_read(32'd1, 128'h62, 1'b0, 4);
    tests++;
    if (strobe_cnt - n0 !== 3) begin
      fails++;
      $display("FAIL drop_strobes: got %0d strobes, required 3", strobe_cnt - n0);
    end
`ifdef OCM_RESP_STATS_EN
    tests++;
    if (beat_count !== 16'd3 || drop_count !== 16'd1) begin
      fails++;
      $display("FAIL stats: got beat=%0d drop=%0d, required 3/1", beat_count, drop_count);
    end
`endif
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    strobe_cnt      = 0;
    mem_en_seen     = 1'b0;
    init_master_txn = 1'b0;
    read_addr_index = '0;
    dfsm_read_ready = 1'b1;
    rd_s1           = '0;
    rd_s2           = '0;
    for (int i = 0; i < 1024; i++) mem[i] = {96'h0, 32'(i * 32'h0101_0101 + 32'h5a)};
    mem[0]    = 128'h61;
    mem[1]    = 128'h62;
    mem[2]    = 128'h63;
    mem[3]    = 128'h61;
    mem[5]    = 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d;
    mem[1023] = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_stats();

    repeat (3) tick();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d beats outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
